// File: rtl/branch_net_pkg.sv
// Shared definitions for the branch-net configuration path: port count,
// per-source destination width, configuration word type and loader states.
package branch_net_pkg;

  localparam int N_PORTS = 16;
  localparam int SEL_W   = 4;
  localparam int CONF_W  = N_PORTS * SEL_W;

  typedef logic [CONF_W-1:0] branch_conf_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/branch_perm_check.sv
// Combinational permutation check of a branch configuration. Each source
// field selects one destination; the mapping is a permutation when every
// destination is hit and no destination is hit twice.
module branch_perm_check #(
  parameter int N_PORTS = 16,
  parameter int SEL_W   = 4
) (
  input  logic [N_PORTS*SEL_W-1:0] conf,
  output logic                     is_perm
);
  import branch_net_pkg::*;

  logic [N_PORTS-1:0] hit;
  logic [N_PORTS-1:0] coll;

  // Per-destination one-hot OR of all sources plus a collision flag when a
  // destination is selected by a second source.
  always_comb begin
    hit  = '0;
    coll = '0;
    for (int d = 0; d < N_PORTS; d++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (conf[i*SEL_W +: SEL_W] == SEL_W'(d)) begin
          coll[d] = coll[d] | hit[d];
          hit[d]  = 1'b1;
        end
      end
    end
  end

  assign is_perm = (&hit) & ~(|coll);

endmodule

// File: rtl/branch_conf_loader.sv
// Configuration front-end for the branch selector. Word-serial frames are
// assembled into a shadow register; a commit handshake copies the shadow
// into the active branch_net_conf so the selector never sees a partial frame.
// Optional build macro BRANCH_CONF_PERM_CHECK_EN: reject commits whose
// shadow is not a permutation of the destinations.
module branch_conf_loader #(
  parameter int                      N_PORTS    = 16,
  parameter int                      SEL_W      = 4,
  parameter int                      WORD_W     = 16,
  parameter logic [N_PORTS*SEL_W-1:0] RESET_CONF = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WORD_W-1:0]        cfg_data,
  input  logic                     cfg_last,
  input  logic                     commit_req,
  output logic                     commit_ack,
  output logic                     cfg_err,
  output logic                     conf_valid,
  output logic [N_PORTS*SEL_W-1:0] branch_net_conf
);
  import branch_net_pkg::*;

  localparam int ACT_W = N_PORTS * SEL_W;
  localparam int BEATS = ACT_W / WORD_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Parameter sanity: the field width must index exactly N_PORTS
  // destinations and the frame must be a whole number of words.
  if (SEL_W != $clog2(N_PORTS) || (ACT_W % WORD_W) != 0) begin : g_bad_params
    $error("branch_conf_loader: inconsistent N_PORTS/SEL_W/WORD_W");
  end

  loader_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [ACT_W-1:0]   shadow;
  logic               accept;
  logic               last_beat;
  logic               commit_ok;

  assign cfg_ready = (state == LOAD);
  assign accept    = cfg_valid & cfg_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

`ifdef BRANCH_CONF_PERM_CHECK_EN
  logic is_perm;

  branch_perm_check #(
    .N_PORTS (N_PORTS),
    .SEL_W   (SEL_W)
  ) u_perm_check (
    .conf    (shadow),
    .is_perm (is_perm)
  );

  assign commit_ok = is_perm;
`else
  // Any mapping is legal; colliding sources are ORed by the selector.
  assign commit_ok = 1'b1;
`endif

  // Loader FSM: frame assembly in LOAD, commit handshake in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LOAD;
      cnt             <= '0;
      shadow          <= '0;
      branch_net_conf <= RESET_CONF;
      conf_valid      <= 1'b0;
      commit_ack      <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        LOAD: begin
          // commit_req is deliberately ignored until a frame is complete.
          if (accept) begin
            if (last_beat && cfg_last) begin
              shadow[int'(cnt)*WORD_W +: WORD_W] <= cfg_data;
              cnt   <= '0;
              state <= FULL;
            end else if (!last_beat && !cfg_last) begin
              shadow[int'(cnt)*WORD_W +: WORD_W] <= cfg_data;
              cnt <= cnt + 1'b1;
            end else begin
              // Early or missing cfg_last: drop the word and restart framing.
              cnt     <= '0;
              cfg_err <= 1'b1;
            end
          end
        end
        FULL: begin
          if (commit_req) begin
            state <= LOAD;
            if (commit_ok) begin
              branch_net_conf <= shadow;
              conf_valid      <= 1'b1;
              commit_ack      <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_conf_loader.md
Name: branch_conf_loader

Overview:
- Sequential configuration front-end for the 16x16 branch selector. Drives its 64-bit `branch_net_conf` bus: 16 source fields of 4 bits each; field i is the destination index for `merge_set_in[i]`.
- Receives configuration as a framed stream of narrow words over a valid/ready handshake and assembles it into a shadow register.
- The shadow is copied to the active register only on an explicit commit handshake, so the selector never sees a partially written configuration.

Parameters:
- N_PORTS, 16, number of merge-set sources/destinations.
- SEL_W, 4, destination index width per source; must equal clog2(N_PORTS).
- WORD_W, 16, config stream word width; N_PORTS*SEL_W must be a multiple of WORD_W.
- RESET_CONF, 64'h0, active configuration after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  loader accepts a word this cycle
- cfg_data  in  WORD_W  config word
- cfg_last  in  1  final word of the frame
- commit_req  in  1  request shadow-to-active transfer
- commit_ack  out  1  one-cycle pulse; active register updated
- cfg_err  out  1  one-cycle pulse; frame rejected
- conf_valid  out  1  high once any commit has completed
- branch_net_conf  out  N_PORTS*SEL_W  active configuration; feeds the branch selector directly

Behaviour:
- Reset (async assert, sync release):
  - state = LOAD, beat counter = 0, shadow = 0, branch_net_conf = RESET_CONF.
  - conf_valid = 0, commit_ack = 0, cfg_err = 0, cfg_ready = 1 after release.
- Derived values: BEATS = N_PORTS*SEL_W/WORD_W (4 at defaults); counter width is clog2(BEATS).
- A word is accepted when cfg_valid && cfg_ready.
- Beat k writes shadow[k*WORD_W +: WORD_W]; beat 0 is least significant.
- State LOAD: cfg_ready = 1.
  - Accepted word with cnt < BEATS-1 and !cfg_last: write shadow, cnt++.
  - Accepted word with cnt == BEATS-1 and cfg_last: write shadow, go to FULL, cnt = 0.
  - Framing error (cfg_last before the final beat, or final beat without cfg_last): word discarded, cfg_err pulses the next cycle, cnt = 0, stay in LOAD. Shadow contents are don't-care until the next complete frame.
- State FULL: cfg_ready = 0.
  - commit_req: branch_net_conf <= shadow on that edge; commit_ack high for exactly the following cycle; conf_valid <= 1; go to LOAD.
  - Latency from commit_req sampled to new branch_net_conf and ack: 1 cycle.
- commit_req in LOAD is ignored: no ack, no error, branch_net_conf unchanged.
- commit_req held high across consecutive cycles produces one ack per completed frame only.
- branch_net_conf is registered and changes only on a commit edge or reset.
- Reset mid-frame discards the partial shadow and restores RESET_CONF.
- cfg_data is ignored when cfg_valid is low; X on cfg_data with cfg_valid low must not propagate.

Optional Feature:
- Macro: BRANCH_CONF_PERM_CHECK_EN.
- Defined: on commit_req in FULL, the shadow is checked to be a permutation (every destination 0..N_PORTS-1 used exactly once).
  - Pass: normal commit.
  - Fail: no transfer, commit_ack stays 0, cfg_err pulses the next cycle, state returns to LOAD (shadow dropped).
  - Check is combinational on the registered shadow, so latency is unchanged.
- Undefined: any mapping is committed. Many-to-one fan-in is legal; the selector ORs colliding sources.

Decomposition:
- Package `branch_net_pkg`:
  - constants N_PORTS, SEL_W, CONF_W = N_PORTS*SEL_W;
  - `branch_conf_t` (logic [CONF_W-1:0]);
  - loader state enum {LOAD, FULL}.
- Sub-module `branch_perm_check`: combinational; input shadow conf, output `is_perm`. It builds a per-destination one-hot OR and a per-destination collision detect. Instantiated only under BRANCH_CONF_PERM_CHECK_EN.

Test Plan:
- Reset then idle: branch_net_conf == 0, conf_valid = 0, cfg_ready = 1, no ack or err pulses.
- Frame 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC (last on beat 3), then commit_req: ack one cycle later, branch_net_conf == 64'hFEDCBA9876543210, conf_valid = 1.
- cfg_last on beat 1: cfg_err pulse, branch_net_conf unchanged; a following correct 4-beat frame commits normally.
- commit_req during LOAD at beat 2: no ack, conf unchanged. Complete the frame with cfg_valid held in FULL: cfg_ready = 0, no word consumed until commit.
- Assert rst_n low after beat 2 of a frame: branch_net_conf returns to RESET_CONF immediately (async), counter restarts at beat 0.
- With BRANCH_CONF_PERM_CHECK_EN, frame all-zero (every source to destination 0) plus commit: cfg_err pulse, no ack, conf unchanged. Without the macro the same frame commits and returns an ack.
